// File: rtl/axis_rr_pkt_mux.sv
// rtl/axis_rr_pkt_mux.sv - packet-granular round-robin AXI-Stream mux
// Grant is held from the first beat to the tlast beat; the output is a registered single-entry slice.
module axis_rr_pkt_mux #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic                          axis_clk,
  input  logic                          axis_resetn,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic                          m_tvalid,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tlast,
  output logic [ID_WIDTH-1:0]           m_tid,
  input  logic                          m_tready,
  output logic [NUM_SRC-1:0]            grant
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_SRC-1:0]      r_grant;
  logic [ID_WIDTH-1:0]     r_sel;
  logic [ID_WIDTH-1:0]     r_last;
  logic                    r_m_tvalid;
  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic                    r_m_tlast;
  logic [ID_WIDTH-1:0]     r_m_tid;

  logic                    w_out_free;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_src_hs;
  logic                    w_arb_found;
  logic [ID_WIDTH-1:0]     w_arb_idx;
  logic [NUM_SRC-1:0]      w_arb_onehot;

  // grant is all-zero in IDLE, so gating with it keeps s_tready low there
  assign w_out_free = !r_m_tvalid || m_tready;
  assign s_tready   = r_grant & {NUM_SRC{w_out_free}};
  assign w_src_hs   = (r_state == ST_BUSY) && w_sel_valid && w_out_free;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
        w_sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // search order starts just after the previous winner and wraps
  always_comb begin
    int pos;
    w_arb_found  = 1'b0;
    w_arb_idx    = '0;
    w_arb_onehot = '0;
    pos          = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pos = int'(r_last) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_arb_found && (i == pos) && s_tvalid[i]) begin
          w_arb_found     = 1'b1;
          w_arb_idx       = ID_WIDTH'(i);
          w_arb_onehot    = '0;
          w_arb_onehot[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_found) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_src_hs && w_sel_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_sel      <= '0;
      r_last     <= ID_WIDTH'(NUM_SRC - 1);
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_arb_found) begin
        r_grant <= w_arb_onehot;
        r_sel   <= w_arb_idx;
        r_last  <= w_arb_idx;
      end else if (w_src_hs && w_sel_last) begin
        r_grant <= '0;
      end
      if (w_src_hs) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_sel_data;
        r_m_tlast  <= w_sel_last;
        r_m_tid    <= r_sel;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;
  assign grant    = r_grant;

endmodule

// File: tb/tb_axis_rr_pkt_mux.sv
// tb/tb_axis_rr_pkt_mux.sv - bench for axis_rr_pkt_mux
// Three-source instance; randomized traffic checked against a packet-level round-robin model.
module tb_axis_rr_pkt_mux;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int IW = 3;

  logic               axis_clk = 1'b0;
  logic               axis_resetn = 1'b0;
  logic [NS-1:0]      s_tvalid = '0;
  logic [NS*DW-1:0]   s_tdata = '0;
  logic [NS-1:0]      s_tlast = '0;
  logic [NS-1:0]      s_tready;
  logic               m_tvalid;
  logic [DW-1:0]      m_tdata;
  logic               m_tlast;
  logic [IW-1:0]      m_tid;
  logic               m_tready = 1'b1;
  logic [NS-1:0]      grant;

  axis_rr_pkt_mux #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .axis_clk(axis_clk), .axis_resetn(axis_resetn),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_tready(m_tready), .grant(grant)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
    int            tid;
    int            cyc;
  } beat_t;

  beat_t          src_q[NS][$];
  beat_t          obs_q[$];
  beat_t          exp_q[$];
  logic [NS-1:0]  gh[$];
  int             plen[NS][$];
  logic [DW-1:0]  pbase[NS][$];
  int             cyc = 0, passed = 0, total = 0, stall_hits = 0;
  int             gap_pct = 0, rdy_pct = 100, stall_cycles = 0;
  logic [NS-1:0]  hs = '0;
  logic           prev_stall = 1'b0;
  logic [DW-1:0]  prev_data;
  logic           prev_last;
  logic [IW-1:0]  prev_tid;

  task automatic add_pkt(input int s, input int len, input logic [DW-1:0] base);
    for (int j = 0; j < len; j++) begin
      beat_t b;
      b.data = base + DW'(j);
      b.last = (j == len - 1);
      b.first = (j == 0);
      b.tid = s;
      b.cyc = 0;
      src_q[s].push_back(b);
    end
  endtask

  // one clock: drive sources from their queues, then sample both sides at the falling edge
  task automatic cycle();
    @(posedge axis_clk);
    #1;
    axis_resetn = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (src_q[s].size() > 0) begin
        beat_t b;
        b = src_q[s][0];
        s_tvalid[s] = (s_tvalid[s] && !hs[s]) || b.first || ($urandom_range(99) >= gap_pct);
        s_tdata[s*DW +: DW] = b.data;
        s_tlast[s] = b.last;
      end else begin
        s_tvalid[s] = 1'b0;
        s_tlast[s] = 1'b0;
      end
    end
    if (stall_cycles > 0) begin
      m_tready = 1'b0;
      stall_cycles--;
    end else begin
      m_tready = ($urandom_range(99) < rdy_pct);
    end
    @(negedge axis_clk);
    if (prev_stall) begin
      total++;
      stall_hits++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last || m_tid !== prev_tid)
        $display("FAIL stall_hold: got v=%0b d=%0h l=%0b id=%0d expected v=1 d=%0h l=%0b id=%0d",
                 m_tvalid, m_tdata, m_tlast, m_tid, prev_data, prev_last, prev_tid);
      else passed++;
    end
    if (m_tvalid && !m_tready) begin
      total++;
      if (s_tready !== '0) $display("FAIL stall_sready: got %b expected 000", s_tready);
      else passed++;
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
    prev_tid = m_tid;
    hs = s_tvalid & s_tready;
    for (int s = 0; s < NS; s++) if (hs[s]) void'(src_q[s].pop_front());
    if (m_tvalid && m_tready) begin
      beat_t o;
      o.data = m_tdata;
      o.last = m_tlast;
      o.first = 1'b0;
      o.tid = int'(m_tid);
      o.cyc = cyc;
      obs_q.push_back(o);
    end
    gh.push_back(grant);
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge axis_clk);
    #1;
    axis_resetn = 1'b0;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    hs = '0;
    for (int s = 0; s < NS; s++) src_q[s].delete();
    obs_q.delete();
    stall_cycles = 0;
    prev_stall = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic run_until(input int n, input int bound);
    int k = 0;
    while (obs_q.size() < n && k < bound) begin
      cycle();
      k++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); else passed++;
    total++;
    if (grant !== '0) $display("FAIL reset_grant: got %b expected 000", grant); else passed++;
    total++;
    if (s_tready !== '0) $display("FAIL reset_sready: got %b expected 000", s_tready); else passed++;
    total++;
    if (m_tdata !== '0 || m_tlast !== 1'b0 || m_tid !== '0)
      $display("FAIL reset_outregs: got d=%0h l=%0b id=%0d expected 0 0 0", m_tdata, m_tlast, m_tid);
    else passed++;
  endtask

  task automatic test_single();
    int c0;
    apply_reset();
    gap_pct = 0;
    rdy_pct = 100;
    add_pkt(0, 3, 32'hA0);
    c0 = cyc;
    run_until(3, 20);
    total++;
    if (obs_q.size() != 3) $display("FAIL single_count: got %0d expected 3", obs_q.size());
    else begin
      passed++;
      for (int j = 0; j < 3; j++) begin
        total++;
        if (obs_q[j].data !== 32'hA0 + DW'(j) || obs_q[j].tid != 0 || obs_q[j].last !== (j == 2))
          $display("FAIL single_beat%0d: got d=%0h id=%0d l=%0b expected d=%0h id=0 l=%0b",
                   j, obs_q[j].data, obs_q[j].tid, obs_q[j].last, 32'hA0 + j, (j == 2));
        else passed++;
      end
      total++;
      if (obs_q[0].cyc - c0 != 2) $display("FAIL single_latency: got %0d expected 2", obs_q[0].cyc - c0);
      else passed++;
    end
    total++;
    if (gh.size() <= c0 + 4) $display("FAIL single_grant: got %0d cycles expected %0d", gh.size(), c0 + 5);
    else if (gh[c0+1] !== 3'b001 || gh[c0+4] !== 3'b000)
      $display("FAIL single_grant: got %b,%b expected 001,000", gh[c0+1], gh[c0+4]);
    else passed++;
  endtask

  task automatic test_contention();
    logic [DW-1:0] ed[4];
    int            et[4];
    ed = '{32'h10, 32'h11, 32'h20, 32'h21};
    et = '{0, 0, 1, 1};
    apply_reset();
    add_pkt(0, 2, 32'h10);
    add_pkt(1, 2, 32'h20);
    run_until(4, 30);
    total++;
    if (obs_q.size() != 4) $display("FAIL contention_count: got %0d expected 4", obs_q.size());
    else begin
      passed++;
      for (int j = 0; j < 4; j++) begin
        total++;
        if (obs_q[j].data !== ed[j] || obs_q[j].tid != et[j])
          $display("FAIL contention_beat%0d: got d=%0h id=%0d expected d=%0h id=%0d",
                   j, obs_q[j].data, obs_q[j].tid, ed[j], et[j]);
        else passed++;
      end
      total++;
      if (obs_q[2].cyc - obs_q[1].cyc != 2)
        $display("FAIL contention_gap: got %0d expected 2", obs_q[2].cyc - obs_q[1].cyc);
      else passed++;
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 1, $urandom);
      add_pkt(1, 1, $urandom);
    end
    run_until(8, 60);
    total++;
    if (obs_q.size() != 8) $display("FAIL fair_count: got %0d expected 8", obs_q.size());
    else begin
      passed++;
      for (int j = 0; j < 8; j++) begin
        total++;
        if (obs_q[j].tid != j % 2) $display("FAIL fair_tid%0d: got %0d expected %0d", j, obs_q[j].tid, j % 2);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int s0, k;
    bit done;
    apply_reset();
    add_pkt(0, 4, 32'h50);
    s0 = stall_hits;
    k = 0;
    done = 0;
    while (obs_q.size() < 4 && k < 60) begin
      if (obs_q.size() == 2 && !done) begin
        stall_cycles = 5;
        done = 1;
      end
      cycle();
      k++;
    end
    total++;
    if (obs_q.size() != 4) $display("FAIL bp_count: got %0d expected 4", obs_q.size());
    else begin
      passed++;
      for (int j = 0; j < 4; j++) begin
        total++;
        if (obs_q[j].data !== 32'h50 + DW'(j))
          $display("FAIL bp_beat%0d: got %0h expected %0h", j, obs_q[j].data, 32'h50 + j);
        else passed++;
      end
    end
    total++;
    if (stall_hits - s0 < 4) $display("FAIL bp_stalled: got %0d held cycles expected >=4", stall_hits - s0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    add_pkt(0, 4, 32'h60);
    run_until(2, 20);
    apply_reset();
    total++;
    if (m_tvalid !== 1'b0 || grant !== '0 || s_tready !== '0)
      $display("FAIL midreset_state: got v=%b g=%b r=%b expected 0 000 000", m_tvalid, grant, s_tready);
    else passed++;
    add_pkt(1, 1, 32'h71);
    add_pkt(0, 1, 32'h70);
    run_until(2, 20);
    repeat (5) cycle();
    total++;
    if (obs_q.size() != 2) $display("FAIL midreset_count: got %0d expected 2", obs_q.size());
    else begin
      passed++;
      total++;
      if (obs_q[0].tid != 0 || obs_q[0].data !== 32'h70 || obs_q[1].tid != 1 || obs_q[1].data !== 32'h71)
        $display("FAIL midreset_order: got %0d:%0h %0d:%0h expected 0:70 1:71",
                 obs_q[0].tid, obs_q[0].data, obs_q[1].tid, obs_q[1].data);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    add_pkt(2, 1, 32'hC2);
    run_until(1, 20);
    total++;
    if (obs_q.size() != 1 || obs_q[0].tid != 2)
      $display("FAIL wrap_first: got %0d beats expected 1 beat from src2", obs_q.size());
    else passed++;
    obs_q.delete();
    add_pkt(2, 1, 32'hC3);
    add_pkt(0, 1, 32'hC0);
    run_until(2, 20);
    total++;
    if (obs_q.size() != 2) $display("FAIL wrap_count: got %0d expected 2", obs_q.size());
    else if (obs_q[0].tid != 0 || obs_q[0].data !== 32'hC0 || obs_q[1].tid != 2)
      $display("FAIL wrap_order: got %0d:%0h then %0d expected 0:c0 then 2",
               obs_q[0].tid, obs_q[0].data, obs_q[1].tid);
    else passed++;
  endtask

  // model: whole packets, granted in rotation among sources that still have packets queued
  task automatic test_random();
    int  ptr, s, n;
    bit  found;
    apply_reset();
    gap_pct = 30;
    rdy_pct = 70;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      plen[i].delete();
      pbase[i].delete();
      n = $urandom_range(2, 5);
      for (int p = 0; p < n; p++) begin
        plen[i].push_back($urandom_range(1, 4));
        pbase[i].push_back($urandom);
        add_pkt(i, plen[i][p], pbase[i][p]);
      end
    end
    ptr = NS - 1;
    found = 1;
    while (found) begin
      found = 0;
      s = 0;
      for (int k = 1; k <= NS; k++) begin
        if (!found && plen[(ptr + k) % NS].size() > 0) begin
          found = 1;
          s = (ptr + k) % NS;
        end
      end
      if (found) begin
        for (int j = 0; j < plen[s][0]; j++) begin
          beat_t b;
          b.data = pbase[s][0] + DW'(j);
          b.last = (j == plen[s][0] - 1);
          b.first = (j == 0);
          b.tid = s;
          b.cyc = 0;
          exp_q.push_back(b);
        end
        void'(plen[s].pop_front());
        void'(pbase[s].pop_front());
        ptr = s;
      end
    end
    run_until(exp_q.size(), 3000);
    repeat (10) cycle();
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j].data !== exp_q[j].data || obs_q[j].tid != exp_q[j].tid || obs_q[j].last !== exp_q[j].last)
        $display("FAIL rand_beat%0d: got d=%0h id=%0d l=%0b expected d=%0h id=%0d l=%0b", j,
                 obs_q[j].data, obs_q[j].tid, obs_q[j].last, exp_q[j].data, exp_q[j].tid, exp_q[j].last);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

endmodule
